// File: rtl/ov_power_seq_pkg.sv
// Shared types and constants for the OV sensor power-up and configuration sequencer.
package ov_power_seq_pkg;

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned RETRY_W = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PWDN   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_CFG    = 3'd3,
    S_READY  = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic start;
    logic ready;
    logic fail;
  } pins_t;

  // Static pin levels for a state; the start pulse is added by the FSM on entry.
  function automatic pins_t state_pins(state_e s);
    pins_t p;
    p       = '0;
    p.pwdn  = (s == S_PWDN);
    p.rst_n = !((s == S_PWDN) || (s == S_RST));
    p.ready = (s == S_READY);
    p.fail  = (s == S_FAIL);
    return p;
  endfunction

endpackage

// File: rtl/ov_phase_timer.sv
// Clear-and-count phase timer with a terminal-count compare against a per-state limit.
module ov_phase_timer
  import ov_power_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/ov_power_seq.sv
// Sensor bring-up sequencer: timed PWDN/RESETB phases, then SCCB configuration
// with timeout and bounded retry; outputs registered from the next state.
module ov_power_seq
  import ov_power_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0]   T_PWDN    = 20'd100000,
  parameter logic [CNT_W-1:0]   T_RST     = 20'd50000,
  parameter logic [CNT_W-1:0]   T_SETTLE  = 20'd200000,
  parameter logic [CNT_W-1:0]   T_CFG_TO  = 20'hfffff,
  parameter logic [RETRY_W-1:0] MAX_RETRY = 2'd2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       restart_i,
  input  logic       cfg_done_i,
  input  logic       cfg_err_i,
  output logic       cam_pwdn_o,
  output logic       cam_rst_n_o,
  output logic       cfg_start_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_o
);

  state_e             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  pins_t              pins_q, pins_d;
  logic [CNT_W-1:0]   limit_c;
  logic               enter_c;
  logic               tc_c;

  // Terminal compare value for the phase currently being timed.
  always_comb begin
    limit_c = '0;
    case (state_q)
      S_PWDN:   limit_c = T_PWDN;
      S_RST:    limit_c = T_RST;
      S_SETTLE: limit_c = T_SETTLE;
      S_CFG:    limit_c = T_CFG_TO;
      default:  limit_c = '0;
    endcase
  end

  ov_phase_timer u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (enter_c),
    .limit_i (limit_c),
    .tc_c    (tc_c)
  );

  // Next state; enter_c marks any state entry, including S_CFG re-entry on retry.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    enter_c = 1'b0;
    if (restart_i) begin
      state_d = S_PWDN;
      retry_d = '0;
      enter_c = 1'b1;
    end else begin
      case (state_q)
        S_PWDN: begin
          if (tc_c) begin
            state_d = S_RST;
            enter_c = 1'b1;
          end
        end
        S_RST: begin
          if (tc_c) begin
            state_d = S_SETTLE;
            enter_c = 1'b1;
          end
        end
        S_SETTLE: begin
          if (tc_c) begin
            state_d = S_CFG;
            enter_c = 1'b1;
          end
        end
        S_CFG: begin
          // Engine responses are not valid on the start-pulse cycle.
          if (!pins_q.start) begin
            if (cfg_done_i) begin
              state_d = S_READY;
              enter_c = 1'b1;
            end else if (cfg_err_i || tc_c) begin
              enter_c = 1'b1;
              if (retry_q < MAX_RETRY) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_CFG;
              end else begin
                state_d = S_FAIL;
              end
            end
          end
        end
        S_READY, S_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_PWDN;
          retry_d = '0;
          enter_c = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pins_d       = state_pins(state_d);
    pins_d.start = (state_d == S_CFG) && enter_c;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_PWDN;
      retry_q <= '0;
      pins_q  <= state_pins(S_PWDN);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      pins_q  <= pins_d;
    end
  end

  assign cam_pwdn_o  = pins_q.pwdn;
  assign cam_rst_n_o = pins_q.rst_n;
  assign cfg_start_o = pins_q.start;
  assign ready_o     = pins_q.ready;
  assign fail_o      = pins_q.fail;
  assign state_o     = state_q;
  assign retry_o     = retry_q;

endmodule

// File: tb/tb_ov_power_seq.sv
// Directed bench for ov_power_seq with short phase times and a queue of expected output words.
module tb_ov_power_seq;

  localparam logic [2:0] ST_PWDN   = 3'd0;
  localparam logic [2:0] ST_RST    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CFG    = 3'd3;
  localparam logic [2:0] ST_READY  = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_err = 1'b0;
  logic       cam_pwdn, cam_rst_n, cfg_start, ready, fail;
  logic [2:0] state;
  logic [1:0] retry;
  logic [9:0] obs;

  int total = 0;
  int bad = 0;

  logic [9:0] sb_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  ov_power_seq #(
    .T_PWDN    (20'd4),
    .T_RST     (20'd3),
    .T_SETTLE  (20'd5),
    .T_CFG_TO  (20'd10),
    .MAX_RETRY (2'd2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .restart_i   (restart),
    .cfg_done_i  (cfg_done),
    .cfg_err_i   (cfg_err),
    .cam_pwdn_o  (cam_pwdn),
    .cam_rst_n_o (cam_rst_n),
    .cfg_start_o (cfg_start),
    .ready_o     (ready),
    .fail_o      (fail),
    .state_o     (state),
    .retry_o     (retry)
  );

  assign obs = {cam_pwdn, cam_rst_n, cfg_start, ready, fail, state, retry};

  // Expected output word {pwdn, rst_n, start, ready, fail, state, retry}.
  function automatic logic [9:0] ex(input logic [2:0] st, input logic [1:0] rt, input logic s);
    logic pw, rn, rd, fl;
    pw = (st == ST_PWDN);
    rn = (st != ST_PWDN) && (st != ST_RST);
    rd = (st == ST_READY);
    fl = (st == ST_FAIL);
    return {pw, rn, s, rd, fl, st, rt};
  endfunction

  task automatic check_front();
    logic [9:0] e;
    string      t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  task automatic expect_now(input logic [9:0] e, input string tag);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    check_front();
  endtask

  // One clock: drive inputs at the falling edge, check just after the rising edge.
  task automatic cyc(input logic d, input logic e, input logic r,
                     input logic [9:0] exp_v, input string tag);
    @(negedge clk);
    cfg_done = d;
    cfg_err  = e;
    restart  = r;
    sb_q.push_back(exp_v);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic run(input logic [2:0] st, input logic [1:0] rt, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, ex(st, rt, 1'b0), tag);
  endtask

  // From S_PWDN with cnt=0: pwdn falls on edge 4, rst_n rises on edge 7, start on edge 12.
  task automatic bringup(input string tag);
    run(ST_PWDN, 2'd0, 3, {tag, "_pwdn"});
    cyc(1'b0, 1'b0, 1'b0, ex(ST_RST, 2'd0, 1'b0), {tag, "_pwdn_fall"});
    run(ST_RST, 2'd0, 2, {tag, "_rst"});
    cyc(1'b0, 1'b0, 1'b0, ex(ST_SETTLE, 2'd0, 1'b0), {tag, "_rst_rise"});
    run(ST_SETTLE, 2'd0, 4, {tag, "_settle"});
    cyc(1'b0, 1'b0, 1'b0, ex(ST_CFG, 2'd0, 1'b1), {tag, "_start"});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_now(ex(ST_PWDN, 2'd0, 1'b0), "reset_values");
    rst_n = 1'b1;

    // Nominal bring-up with done three cycles after the start pulse.
    bringup("nom");
    run(ST_CFG, 2'd0, 3, "nom_cfg_wait");
    cyc(1'b1, 1'b0, 1'b0, ex(ST_READY, 2'd0, 1'b0), "nom_ready");
    run(ST_READY, 2'd0, 2, "nom_ready_hold");

    // Restart from READY, then no response from the engine: two retries, then fail.
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_ready");
    bringup("to");
    run(ST_CFG, 2'd0, 9, "to_wait0");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_CFG, 2'd1, 1'b1), "to_start1");
    run(ST_CFG, 2'd1, 9, "to_wait1");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_CFG, 2'd2, 1'b1), "to_start2");
    run(ST_CFG, 2'd2, 9, "to_wait2");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_FAIL, 2'd2, 1'b0), "to_fail");
    run(ST_FAIL, 2'd2, 2, "fail_hold");

    // Restart held for two cycles; error ignored on start cycle, honoured later.
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_fail");
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_held");
    bringup("err");
    cyc(1'b0, 1'b1, 1'b0, ex(ST_CFG, 2'd0, 1'b0), "err_on_start_ignored");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_CFG, 2'd0, 1'b0), "err_wait");
    cyc(1'b0, 1'b1, 1'b0, ex(ST_CFG, 2'd1, 1'b1), "err_retry_start");
    run(ST_CFG, 2'd1, 2, "err_wait1");
    cyc(1'b1, 1'b0, 1'b0, ex(ST_READY, 2'd1, 1'b0), "err_then_ready");

    // Done, error and timeout on the same cycle: done wins.
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_ready2");
    bringup("tie");
    run(ST_CFG, 2'd0, 9, "tie_wait");
    cyc(1'b1, 1'b1, 1'b0, ex(ST_READY, 2'd0, 1'b0), "tie_done_wins");

    // Restart mid-settle, full timing repeats, then async reset mid-configuration.
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_ready3");
    run(ST_PWDN, 2'd0, 3, "ms_pwdn");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_RST, 2'd0, 1'b0), "ms_pwdn_fall");
    run(ST_RST, 2'd0, 2, "ms_rst");
    cyc(1'b0, 1'b0, 1'b0, ex(ST_SETTLE, 2'd0, 1'b0), "ms_rst_rise");
    run(ST_SETTLE, 2'd0, 2, "ms_settle");
    cyc(1'b0, 1'b0, 1'b1, ex(ST_PWDN, 2'd0, 1'b0), "restart_settle");
    bringup("ms");
    run(ST_CFG, 2'd0, 2, "ms_cfg");
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(ex(ST_PWDN, 2'd0, 1'b0), "async_reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      expect_now(ex(ST_PWDN, 2'd0, 1'b0), "reset_hold");
    end
    rst_n = 1'b1;
    bringup("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
